// File: rtl/fabric_cfg_loader_if.sv
// Configuration word stream into fabric_cfg_loader: valid/ready handshake.
// The master drives words; the slave (the loader) returns ready.
interface fabric_cfg_loader_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fabric_cfg_loader.sv
// Serializes configuration words LSB-first into the CLB scan chain, then pulses the commit strobe.
// Define FABRIC_CFG_READBACK_EN to add capture of the chain tail (chain_in -> rb_data/rb_valid).
module fabric_cfg_loader #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CHAIN_LEN  = 1024,
    parameter int unsigned SET_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    fabric_cfg_loader_if.slave                 cfg_in,
    output logic                               cfg_shift,
    output logic                               cfg_cen,
    output logic                               cfg_set,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count
`ifdef FABRIC_CFG_READBACK_EN
    ,
    input  logic                               chain_in,
    output logic [WORD_W-1:0]                  rb_data,
    output logic                               rb_valid
`endif
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned LEN_W = $clog2(WORD_W + 1);
    localparam int unsigned SET_W = $clog2(SET_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StWaitWord, StShift, StSet, StDone} state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [LEN_W-1:0]   word_left_q, word_left_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic               cfg_shift_q, cfg_cen_q, cfg_set_q, busy_q, done_q;

    logic               abort_hit;
    logic               start_hit;
    logic               last_bit;
    logic [31:0]        bits_left;
    logic [LEN_W-1:0]   next_len;

    assign abort_hit = abort && (state_q != StIdle);
    assign start_hit = start && (state_q == StIdle);
    assign last_bit  = (state_q == StShift) && (32'(bit_count_q) == CHAIN_LEN - 1);

    // A word never shifts past the end of the chain: the final word may be partial.
    assign bits_left = CHAIN_LEN - 32'(bit_count_q);
    assign next_len  = (bits_left > WORD_W) ? LEN_W'(WORD_W) : LEN_W'(bits_left);

    assign cfg_in.in_ready = (state_q == StWaitWord);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        word_left_d = word_left_q;
        bit_count_d = bit_count_q;
        set_cnt_d   = set_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_hit) begin
                    state_d     = StWaitWord;
                    bit_count_d = '0;
                end
            end
            StWaitWord: begin
                if (cfg_in.in_valid) begin
                    state_d     = StShift;
                    word_d      = cfg_in.in_data;
                    word_left_d = next_len;
                end
            end
            StShift: begin
                bit_count_d = bit_count_q + CNT_W'(1);
                word_d      = word_q >> 1;
                word_left_d = word_left_q - LEN_W'(1);
                if (last_bit) begin
                    state_d   = StSet;
                    set_cnt_d = '0;
                end else if (word_left_q == LEN_W'(1)) begin
                    state_d = StWaitWord;
                end
            end
            StSet: begin
                if (set_cnt_q == SET_W'(SET_CYCLES - 1)) begin
                    state_d = StDone;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition; bit_count is left for post-mortem inspection.
        if (abort_hit) begin
            state_d     = StIdle;
            bit_count_d = bit_count_q;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            word_left_q <= '0;
            bit_count_q <= '0;
            set_cnt_q   <= '0;
            cfg_shift_q <= 1'b0;
            cfg_cen_q   <= 1'b0;
            cfg_set_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            word_left_q <= word_left_d;
            bit_count_q <= bit_count_d;
            set_cnt_q   <= set_cnt_d;
            cfg_shift_q <= (state_d == StShift) && word_d[0];
            cfg_cen_q   <= (state_d == StShift);
            cfg_set_q   <= (state_d == StSet);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
        end
    end

    assign cfg_shift = cfg_shift_q;
    assign cfg_cen   = cfg_cen_q;
    assign cfg_set   = cfg_set_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_count = bit_count_q;

`ifdef FABRIC_CFG_READBACK_EN
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
    logic [WORD_W-1:0] rb_word;
    logic [LEN_W-1:0]  rb_cnt_q, rb_cnt_d;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;
    logic              rb_emit;

    // The chain tail is sampled on every shift cycle; bits accumulate LSB-first.
    always_comb begin
        rb_acc_d = rb_acc_q;
        rb_cnt_d = rb_cnt_q;
        rb_word  = rb_acc_q | (WORD_W'(chain_in) << rb_cnt_q);
        rb_emit  = 1'b0;
        if (cfg_cen_q) begin
            rb_acc_d = rb_word;
            rb_cnt_d = rb_cnt_q + LEN_W'(1);
            if ((rb_cnt_q == LEN_W'(WORD_W - 1)) || last_bit) begin
                rb_emit  = 1'b1;
                rb_acc_d = '0;
                rb_cnt_d = '0;
            end
        end
        if (start_hit || abort_hit) begin
            rb_emit  = 1'b0;
            rb_acc_d = '0;
            rb_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_acc_q   <= '0;
            rb_cnt_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_acc_q   <= rb_acc_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_valid_q <= rb_emit;
            if (rb_emit) begin
                rb_data_q <= rb_word;
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`endif

endmodule
